// File: rtl/instruction_fetch.sv
// MIPS fetch stage: fetch PC, internal word-addressed instruction memory and the IF/ID register.
// Handles redirect flushes, load-use stalls and halting when the PC leaves program memory.
module instruction_fetch #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter logic [31:0] NOP        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    input  logic        imem_we,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    output logic [31:0] IR,
    output logic [31:0] PC,
    output logic        if_valid,
    output logic        halted,
    output logic [31:0] fetch_cnt
);

    localparam int unsigned AW      = $clog2(IMEM_DEPTH);
    localparam logic [29:0] DEPTH_W = 30'(IMEM_DEPTH);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] cnt_q, cnt_d;

    logic [31:0]   imem [IMEM_DEPTH];
    logic [AW-1:0] fidx, widx;
    logic          fetch_ok, wr_ok;
    logic          unused_low_bits;

    assign fidx     = fpc_q[AW+1:2];
    assign widx     = imem_addr[AW+1:2];
    assign fetch_ok = fpc_q[31:2] < DEPTH_W;
    assign wr_ok    = imem_addr[31:2] < DEPTH_W;

    assign unused_low_bits = ^{imem_addr[1:0], redir_pc[1:0]};

    // Writes land via NBA, so a same-edge fetch of that word sees the old contents.
    always_ff @(posedge clk) begin
        if (imem_we && wr_ok) begin
            imem[widx] <= imem_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (redir_valid) begin
            fpc_d   = {redir_pc[31:2], 2'b00};
            ir_d    = NOP;
            pc_d    = 32'h0;
            valid_d = 1'b0;
            state_d = StRun;
        end else if (state_q == StHalt || stall) begin
            // hold everything
        end else if (fetch_ok) begin
            ir_d    = imem[fidx];
            pc_d    = fpc_q + 32'd4;
            valid_d = 1'b1;
            fpc_d   = fpc_q + 32'd4;
            cnt_d   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
        end else begin
            ir_d    = NOP;
            pc_d    = 32'h0;
            valid_d = 1'b0;
            state_d = StHalt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            fpc_q   <= PC_RESET;
            ir_q    <= NOP;
            pc_q    <= 32'h0;
            valid_q <= 1'b0;
            cnt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign IR        = ir_q;
    assign PC        = pc_q;
    assign if_valid  = valid_q;
    assign halted    = (state_q == StHalt);
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: table-driven vectors through a scoreboard queue,
// with a default-depth instance and a 4-word instance sharing the same stimulus.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst, stall, redir_valid, imem_we;
    logic [31:0] redir_pc, imem_addr, imem_wdata;

    logic [31:0] ir_b, pc_b, cnt_b, ir_s, pc_s, cnt_s;
    logic        v_b, h_b, v_s, h_s;

    always #5 clk = ~clk;

    instruction_fetch dut_big (
        .clk(clk), .rst(rst), .stall(stall), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .IR(ir_b), .PC(pc_b), .if_valid(v_b), .halted(h_b), .fetch_cnt(cnt_b)
    );

    instruction_fetch #(.IMEM_DEPTH(4)) dut_small (
        .clk(clk), .rst(rst), .stall(stall), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .IR(ir_s), .PC(pc_s), .if_valid(v_s), .halted(h_s), .fetch_cnt(cnt_s)
    );

    typedef struct {
        logic        sel;   // 0: default-depth DUT, 1: 4-word DUT
        logic        rs;
        logic        st;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] ir;
        logic [31:0] pc;
        logic        v;
        logic        h;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic sel, input logic rs, input logic st, input logic rv,
                                input logic [31:0] rpc, input logic [31:0] ir,
                                input logic [31:0] pc, input logic v, input logic h,
                                input logic [31:0] cnt);
        vec_t r;
        r.sel = sel; r.rs = rs; r.st = st; r.rv = rv; r.rpc = rpc;
        r.ir = ir; r.pc = pc; r.v = v; r.h = h; r.cnt = cnt;
        return r;
    endfunction

    task automatic apply(input vec_t vin, input string name);
        vec_t e;
        logic [31:0] a_ir, a_pc, a_cnt;
        logic a_v, a_h;
        exp_q.push_back(vin);
        @(negedge clk);
        rst = vin.rs; stall = vin.st; redir_valid = vin.rv; redir_pc = vin.rpc;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.sel) begin
            a_ir = ir_s; a_pc = pc_s; a_v = v_s; a_h = h_s; a_cnt = cnt_s;
        end else begin
            a_ir = ir_b; a_pc = pc_b; a_v = v_b; a_h = h_b; a_cnt = cnt_b;
        end
        n_vec++;
        if (a_ir !== e.ir || a_pc !== e.pc || a_v !== e.v || a_h !== e.h || a_cnt !== e.cnt) begin
            n_bad++;
            $display("FAIL %s vec%0d: got IR=%h PC=%h v=%b h=%b cnt=%0d, want IR=%h PC=%h v=%b h=%b cnt=%0d",
                     name, n_vec, a_ir, a_pc, a_v, a_h, a_cnt, e.ir, e.pc, e.v, e.h, e.cnt);
        end
    endtask

    logic [31:0] prog [8];

    initial begin
        prog[0] = 32'h20; prog[1] = 32'h22; prog[2] = 32'h2A; prog[3] = 32'h0;
        prog[4] = 32'h44; prog[5] = 32'h55; prog[6] = 32'h66; prog[7] = 32'h77;

        rst = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_pc = 32'h0;
        imem_we = 1'b0; imem_addr = 32'h0; imem_wdata = 32'h0;

        // Program load during reset; the 4-word DUT must drop words 4..7.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            imem_we = 1'b1; imem_addr = 32'(i * 4); imem_wdata = prog[i];
        end
        @(negedge clk);
        imem_we = 1'b0;

        // Plain run
        tbl.push_back(mk(0, 1, 0, 0, 0,     0,     0,     0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,     'h20,  4,     1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,     'h22,  8,     1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0,     'h2A,  12,    1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0,     'h0,   16,    1, 0, 4));
        // Stall holds IF/ID and count
        tbl.push_back(mk(0, 1, 0, 0, 0,     0,     0,     0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,     'h20,  4,     1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,     'h22,  8,     1, 0, 2));
        tbl.push_back(mk(0, 0, 1, 0, 0,     'h22,  8,     1, 0, 2));
        tbl.push_back(mk(0, 0, 1, 0, 0,     'h22,  8,     1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0,     'h2A,  12,    1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0,     'h0,   16,    1, 0, 4));
        // Redirect flushes one slot
        tbl.push_back(mk(0, 1, 0, 0, 0,     0,     0,     0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,     'h20,  4,     1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,     'h22,  8,     1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 'h10,  0,     0,     0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0,     'h44,  'h14,  1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0,     'h55,  'h18,  1, 0, 4));
        // Redirect beats stall; misaligned target truncated
        tbl.push_back(mk(0, 0, 1, 1, 'h13,  0,     0,     0, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0,     'h44,  'h14,  1, 0, 5));
        tbl.push_back(mk(0, 0, 1, 0, 0,     'h44,  'h14,  1, 0, 5));
        // Reset beats a pending redirect and stall
        tbl.push_back(mk(0, 1, 1, 1, 'h40,  0,     0,     0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,     'h20,  4,     1, 0, 1));
        // 4-word DUT: run off the end of memory
        tbl.push_back(mk(1, 1, 0, 0, 0,     0,     0,     0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,     'h20,  4,     1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0,     'h22,  8,     1, 0, 2));
        tbl.push_back(mk(1, 0, 0, 0, 0,     'h2A,  12,    1, 0, 3));
        tbl.push_back(mk(1, 0, 0, 0, 0,     'h0,   16,    1, 0, 4));
        tbl.push_back(mk(1, 0, 0, 0, 0,     0,     0,     0, 1, 4));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], "table");
        end

        // HALT freezes outputs regardless of stall
        for (int i = 0; i < 10; i++) begin
            apply(mk(1, 0, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 1, 4), "halt_hold");
        end
        apply(mk(1, 0, 0, 1, 32'h0, 0, 0, 0, 0, 4), "halt_redir");
        apply(mk(1, 0, 0, 0, 0, 'h20, 4, 1, 0, 5), "halt_refetch0");
        apply(mk(1, 0, 0, 0, 0, 'h22, 8, 1, 0, 6), "halt_refetch1");

        // Same-edge write to the word being fetched returns the old word
        apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "rbw_reset");
        imem_we = 1'b1; imem_addr = 32'h0; imem_wdata = 32'h99;
        apply(mk(0, 0, 0, 0, 0, 'h20, 4, 1, 0, 1), "rbw_old");
        imem_we = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 'h22, 8, 1, 0, 2), "rbw_next");
        apply(mk(0, 0, 0, 1, 32'h0, 0, 0, 0, 0, 2), "rbw_redir");
        apply(mk(0, 0, 0, 0, 0, 'h99, 4, 1, 0, 3), "rbw_new");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
